axil_interconnect_rr_rd: RTL and testbench

//  NxM AXI-Lite read crossbar: NUMBER_MASTER masters, NUMBER_SLAVE address-mapped slaves.
//  Per-slave round-robin arbitration; one outstanding read per master and per slave.

---
 rtl/axil_ic_pkg.sv | 16 +
 rtl/axil_arbiter_rr_rd.sv | 139 +++++++++++++
 rtl/axil_interconnect_rr_rd.sv | 171 +++++++++++++++++
 tb/tb_axil_interconnect_rr_rd.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ic_pkg.sv
// Shared definitions for the AXI-Lite read crossbar: response codes and the
// per-slave arbiter state encoding.
package axil_ic_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axil_arbiter_rr_rd.sv
// Per-slave read arbiter: round-robin grant among requesting masters, the
// IDLE/ADDR/DATA transaction FSM and, when AXIL_RD_TIMEOUT_EN is defined, a
// DATA-phase watchdog that answers the master with SLVERR and then drains the
// late slave response (DRAIN state).
module axil_arbiter_rr_rd
    import axil_ic_pkg::*;
#(
    parameter int NUMBER_MASTER  = 4
`ifdef AXIL_RD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUMBER_MASTER-1:0] req_i,        // masters addressing this slave
    input  logic                     s_arready_i,
    input  logic                     s_rvalid_i,
    input  logic                     rready_i,     // rready of the granted master
    output arb_state_t               state_o,
    output logic [NUMBER_MASTER-1:0] grant_o,      // one-hot, zero while IDLE
    output logic                     s_arvalid_o,
    output logic                     s_rready_o,
    output logic                     err_valid_o   // SLVERR pending to granted master
);

    localparam int PTR_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;

    arb_state_t               state_q;
    logic [NUMBER_MASTER-1:0] grant_q;
    logic [PTR_W-1:0]         ptr_q;
    logic                     arvalid_q;

    logic [PTR_W-1:0]         pick_d;
    logic [PTR_W-1:0]         ptr_d;
    logic [NUMBER_MASTER-1:0] grant_d;

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             drain_q;
`endif

    // Round-robin pick: first requester at or after ptr_q, wrapping around.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        idx    = 0;
        pick_d = '0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NUMBER_MASTER;
            if (req_i[idx]) pick_d = PTR_W'(idx);
        end
        ptr_d   = (pick_d == PTR_W'(NUMBER_MASTER - 1)) ? '0 : pick_d + 1'b1;
        grant_d = {{(NUMBER_MASTER-1){1'b0}}, 1'b1} << pick_d;
    end

    // Transaction FSM with registered grant, pointer and slave arvalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            arvalid_q <= 1'b0;
`ifdef AXIL_RD_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
            drain_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        grant_q   <= grant_d;
                        ptr_q     <= ptr_d;
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready_i) begin
                        arvalid_q <= 1'b0;
                        state_q   <= DATA;
`ifdef AXIL_RD_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                DATA: begin
                    if (s_rvalid_i && rready_i) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
`ifdef AXIL_RD_TIMEOUT_EN
                    else if (!s_rvalid_i) begin
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            err_q   <= 1'b1;
                            drain_q <= 1'b1;
                            state_q <= DRAIN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`endif
                end
                DRAIN: begin
`ifdef AXIL_RD_TIMEOUT_EN
                    // Master SLVERR handshake and the discarded slave beat may finish in either order.
                    if (rready_i)   err_q   <= 1'b0;
                    if (s_rvalid_i) drain_q <= 1'b0;
                    if ((!err_q || rready_i) && (!drain_q || s_rvalid_i)) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
`else
                    grant_q <= '0;
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o     = state_q;
    assign grant_o     = grant_q;
    assign s_arvalid_o = arvalid_q;

`ifdef AXIL_RD_TIMEOUT_EN
    assign s_rready_o  = ((state_q == DATA) && rready_i) || ((state_q == DRAIN) && drain_q);
    assign err_valid_o = (state_q == DRAIN) && err_q;
`else
    assign s_rready_o  = (state_q == DATA) && rready_i;
    assign err_valid_o = 1'b0;
`endif

endmodule

// File: rtl/axil_interconnect_rr_rd.sv
// NxM AXI-Lite read crossbar. Address decode, master/slave muxing and the
// internal DECERR responder live here; each slave port owns one
// axil_arbiter_rr_rd. Optional watchdog: define AXIL_RD_TIMEOUT_EN.
module axil_interconnect_rr_rd
    import axil_ic_pkg::*;
#(
    parameter int NUMBER_MASTER  = 4,
    parameter int NUMBER_SLAVE   = 2,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = '{default: '0},
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] = '{default: AXI_ADDR_WIDTH'(1)},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr  [NUMBER_MASTER],
    input  logic [NUMBER_MASTER-1:0]  m_axil_arvalid,
    output logic [NUMBER_MASTER-1:0]  m_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0] m_axil_rdata   [NUMBER_MASTER],
    output logic [1:0]                m_axil_rresp   [NUMBER_MASTER],
    output logic [NUMBER_MASTER-1:0]  m_axil_rvalid,
    input  logic [NUMBER_MASTER-1:0]  m_axil_rready,
    output logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr  [NUMBER_SLAVE],
    output logic [NUMBER_SLAVE-1:0]   s_axil_arvalid,
    input  logic [NUMBER_SLAVE-1:0]   s_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axil_rdata   [NUMBER_SLAVE],
    input  logic [1:0]                s_axil_rresp   [NUMBER_SLAVE],
    input  logic [NUMBER_SLAVE-1:0]   s_axil_rvalid,
    output logic [NUMBER_SLAVE-1:0]   s_axil_rready
);

    if (NUMBER_MASTER < 2 || NUMBER_SLAVE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axil_interconnect_rr_rd: illegal parameter set");
    end

    logic [NUMBER_SLAVE-1:0]  sel       [NUMBER_MASTER];  // one-hot decoded slave
    logic [NUMBER_MASTER-1:0] miss;                       // address hits no window
    logic [NUMBER_MASTER-1:0] arb_req   [NUMBER_SLAVE];
    logic [NUMBER_MASTER-1:0] arb_grant [NUMBER_SLAVE];
    arb_state_t               arb_state [NUMBER_SLAVE];
    logic [NUMBER_SLAVE-1:0]  arb_err;
    logic [NUMBER_SLAVE-1:0]  gnt_rready;

    logic [NUMBER_MASTER-1:0] out_q;         // read outstanding, masks the master
    logic [NUMBER_MASTER-1:0] dec_ack_q;     // DECERR arready phase
    logic [NUMBER_MASTER-1:0] dec_rvalid_q;  // DECERR response phase

    // Address decode; windows are checked one bit wider so OFFSET+RANGE cannot wrap.
    always_comb begin
        logic [AXI_ADDR_WIDTH:0] addr_x;
        logic [AXI_ADDR_WIDTH:0] lo_x;
        logic [AXI_ADDR_WIDTH:0] hi_x;
        addr_x = '0;
        lo_x   = '0;
        hi_x   = '0;
        for (int m = 0; m < NUMBER_MASTER; m++) begin
            sel[m]  = '0;
            miss[m] = 1'b1;
            // Descending scan: the lowest matching slave index is written last and wins.
            for (int j = NUMBER_SLAVE - 1; j >= 0; j--) begin
                addr_x = {1'b0, m_axil_araddr[m]};
                lo_x   = {1'b0, AXI_ADDR_OFFSET[j]};
                hi_x   = lo_x + {1'b0, AXI_ADDR_RANGE[j]};
                if (addr_x >= lo_x && addr_x < hi_x) begin
                    sel[m]    = '0;
                    sel[m][j] = 1'b1;
                    miss[m]   = 1'b0;
                end
            end
        end
    end

    // Arbiter request vectors; a master with a read outstanding is hidden.
    always_comb begin
        for (int j = 0; j < NUMBER_SLAVE; j++) begin
            for (int m = 0; m < NUMBER_MASTER; m++) begin
                arb_req[j][m] = m_axil_arvalid[m] & sel[m][j] & ~out_q[m];
            end
        end
    end

    for (genvar j = 0; j < NUMBER_SLAVE; j++) begin : g_arb
        axil_arbiter_rr_rd #(
            .NUMBER_MASTER (NUMBER_MASTER)
`ifdef AXIL_RD_TIMEOUT_EN
            ,
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
        ) u_arb (
            .clk_i      (aclk),
            .rst_ni     (aresetn),
            .req_i      (arb_req[j]),
            .s_arready_i(s_axil_arready[j]),
            .s_rvalid_i (s_axil_rvalid[j]),
            .rready_i   (gnt_rready[j]),
            .state_o    (arb_state[j]),
            .grant_o    (arb_grant[j]),
            .s_arvalid_o(s_axil_arvalid[j]),
            .s_rready_o (s_axil_rready[j]),
            .err_valid_o(arb_err[j])
        );
    end

    // Slave-side mux: granted master's address and rready.
    always_comb begin
        for (int j = 0; j < NUMBER_SLAVE; j++) begin
            s_axil_araddr[j] = '0;
            gnt_rready[j]    = |(arb_grant[j] & m_axil_rready);
            for (int m = 0; m < NUMBER_MASTER; m++) begin
                if (arb_grant[j][m] && arb_state[j] == ADDR) s_axil_araddr[j] = m_axil_araddr[m];
            end
        end
    end

    // Master-side mux: AR ready and R channel from the owning arbiter or the DECERR path.
    always_comb begin
        for (int m = 0; m < NUMBER_MASTER; m++) begin
            m_axil_arready[m] = dec_ack_q[m];
            m_axil_rvalid[m]  = dec_rvalid_q[m];
            m_axil_rdata[m]   = '0;
            m_axil_rresp[m]   = dec_rvalid_q[m] ? RESP_DECERR : RESP_OKAY;
            for (int j = 0; j < NUMBER_SLAVE; j++) begin
                if (arb_grant[j][m]) begin
                    case (arb_state[j])
                        ADDR: m_axil_arready[m] = m_axil_arready[m] | s_axil_arready[j];
                        DATA: begin
                            m_axil_rvalid[m] = m_axil_rvalid[m] | s_axil_rvalid[j];
                            m_axil_rdata[m]  = s_axil_rdata[j];
                            m_axil_rresp[m]  = s_axil_rresp[j];
                        end
                        DRAIN: begin
                            m_axil_rvalid[m] = m_axil_rvalid[m] | arb_err[j];
                            if (arb_err[j]) m_axil_rresp[m] = RESP_SLVERR;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-master outstanding tracking and the internal DECERR responder.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q        <= '0;
            dec_ack_q    <= '0;
            dec_rvalid_q <= '0;
        end else begin
            for (int m = 0; m < NUMBER_MASTER; m++) begin
                if (m_axil_arvalid[m] && m_axil_arready[m]) begin
                    out_q[m] <= 1'b1;
                end else if (m_axil_rvalid[m] && m_axil_rready[m]) begin
                    out_q[m] <= 1'b0;
                end

                if (dec_ack_q[m]) begin
                    if (m_axil_arvalid[m]) begin
                        dec_ack_q[m]    <= 1'b0;
                        dec_rvalid_q[m] <= 1'b1;
                    end
                end else if (dec_rvalid_q[m]) begin
                    if (m_axil_rready[m]) dec_rvalid_q[m] <= 1'b0;
                end else if (m_axil_arvalid[m] && miss[m] && !out_q[m]) begin
                    dec_ack_q[m] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_interconnect_rr_rd.sv
// Directed bench for axil_interconnect_rr_rd with a 4x2 map
// (S0 at 0x0000_0000, S1 at 0x0001_0000, 4 KiB each).
module tb_axil_interconnect_rr_rd;
    import axil_ic_pkg::*;

    localparam int NM = 4;
    localparam int NS = 2;
    localparam logic [31:0] OFFS [NS] = '{32'h0000_0000, 32'h0001_0000};
    localparam logic [31:0] RNGS [NS] = '{32'h0000_1000, 32'h0000_1000};

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [31:0]   m_araddr  [NM];
    logic [NM-1:0] m_arvalid;
    logic [NM-1:0] m_arready;
    logic [31:0]   m_rdata   [NM];
    logic [1:0]    m_rresp   [NM];
    logic [NM-1:0] m_rvalid;
    logic [NM-1:0] m_rready;
    logic [31:0]   s_araddr  [NS];
    logic [NS-1:0] s_arvalid;
    logic [NS-1:0] s_arready;
    logic [31:0]   s_rdata   [NS];
    logic [1:0]    s_rresp   [NS];
    logic [NS-1:0] s_rvalid;
    logic [NS-1:0] s_rready;

    int n_checks = 0;
    int n_fail   = 0;

    axil_interconnect_rr_rd #(
        .NUMBER_MASTER  (NM),
        .NUMBER_SLAVE   (NS),
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .AXI_ADDR_OFFSET(OFFS),
        .AXI_ADDR_RANGE (RNGS),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .m_axil_araddr (m_araddr),
        .m_axil_arvalid(m_arvalid),
        .m_axil_arready(m_arready),
        .m_axil_rdata  (m_rdata),
        .m_axil_rresp  (m_rresp),
        .m_axil_rvalid (m_rvalid),
        .m_axil_rready (m_rready),
        .s_axil_araddr (s_araddr),
        .s_axil_arvalid(s_arvalid),
        .s_axil_arready(s_arready),
        .s_axil_rdata  (s_rdata),
        .s_axil_rresp  (s_rresp),
        .s_axil_rvalid (s_rvalid),
        .s_axil_rready (s_rready)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            m_araddr[i] = '0;
        end
        for (int j = 0; j < NS; j++) begin
            s_rdata[j] = '0;
            s_rresp[j] = 2'b00;
        end
        m_arvalid = '0;
        m_rready  = '0;
        s_arready = '0;
        s_rvalid  = '0;

        // Reset state
        tick();
        tick();
        check("rst_m_arready", 32'(m_arready), 32'h0);
        check("rst_m_rvalid",  32'(m_rvalid),  32'h0);
        check("rst_s_arvalid", 32'(s_arvalid), 32'h0);
        check("rst_s_rready",  32'(s_rready),  32'h0);
        check("rst_m_rdata0",  m_rdata[0],     32'h0);
        check("rst_m_rresp0",  32'(m_rresp[0]), 32'h0);
        aresetn = 1'b1;
        tick();

        // 1) M0 reads 0x0004 from S0
        m_araddr[0] = 32'h0000_0004;
        m_arvalid   = 4'b0001;
        #1;
        check("t1_arvalid_before_edge", 32'(s_arvalid), 32'h0);
        tick();
        check("t1_s_arvalid", 32'(s_arvalid), 32'h1);
        check("t1_s_araddr0", s_araddr[0], 32'h0000_0004);
        check("t1_m_arready_wait", 32'(m_arready), 32'h0);
        s_arready[0] = 1'b1;
        #1;
        check("t1_m_arready", 32'(m_arready), 32'h1);
        tick();
        m_arvalid = '0;
        s_arready = '0;
        #1;
        check("t1_s_arvalid_drop", 32'(s_arvalid), 32'h0);
        s_rvalid[0] = 1'b1;
        s_rdata[0]  = 32'hCAFE_0001;
        s_rresp[0]  = RESP_OKAY;
        m_rready    = 4'b0001;
        #1;
        check("t1_m_rvalid", 32'(m_rvalid), 32'h1);
        check("t1_m_rdata0", m_rdata[0], 32'hCAFE_0001);
        check("t1_m_rresp0", 32'(m_rresp[0]), 32'h0);
        check("t1_s_rready", 32'(s_rready), 32'h1);
        tick();
        s_rvalid = '0;
        #1;
        check("t1_m_rvalid_done", 32'(m_rvalid), 32'h0);

        // 2) All masters hammer S1; grants must rotate 0,1,2,3,0
        for (int i = 0; i < NM; i++) m_araddr[i] = 32'h0001_0010;
        m_arvalid    = 4'b1111;
        m_rready     = 4'b1111;
        s_arready[1] = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            int exp_m;
            exp_m = i % NM;
            check($sformatf("t2_grant%0d_arready", i), 32'(m_arready), 32'(1) << exp_m);
            check($sformatf("t2_grant%0d_s_arvalid", i), 32'(s_arvalid), 32'h2);
            tick();
            s_rvalid[1] = 1'b1;
            s_rdata[1]  = 32'hD000_0000 + 32'(i);
            #1;
            check($sformatf("t2_grant%0d_rvalid", i), 32'(m_rvalid), 32'(1) << exp_m);
            check($sformatf("t2_grant%0d_rdata", i), m_rdata[exp_m], 32'hD000_0000 + 32'(i));
            tick();
            s_rvalid[1] = 1'b0;
            if (i == 4) m_arvalid = '0;
            tick();
        end
        s_arready = '0;
        check("t2_idle_s_arvalid", 32'(s_arvalid), 32'h0);

        // 3) M1 reads unmapped 0x8000 -> internal DECERR
        m_araddr[1] = 32'h0000_8000;
        m_arvalid   = 4'b0010;
        #1;
        check("t3_arready_before_edge", 32'(m_arready), 32'h0);
        tick();
        check("t3_arready", 32'(m_arready), 32'h2);
        check("t3_no_s_arvalid", 32'(s_arvalid), 32'h0);
        m_rready = 4'b1101;
        tick();
        m_arvalid = '0;
        #1;
        check("t3_rvalid", 32'(m_rvalid), 32'h2);
        check("t3_rresp1", 32'(m_rresp[1]), 32'h3);
        check("t3_rdata1", m_rdata[1], 32'h0);
        check("t3_no_s_arvalid_r", 32'(s_arvalid), 32'h0);
        tick();
        check("t3_rvalid_held", 32'(m_rvalid), 32'h2);
        m_rready = 4'b1111;
        tick();
        check("t3_rvalid_done", 32'(m_rvalid), 32'h0);

        // 4) M0->S0 and M2->S1 concurrently
        m_araddr[0] = 32'h0000_0100;
        m_araddr[2] = 32'h0001_0020;
        m_arvalid   = 4'b0101;
        tick();
        check("t4_s_arvalid", 32'(s_arvalid), 32'h3);
        check("t4_s_araddr0", s_araddr[0], 32'h0000_0100);
        check("t4_s_araddr1", s_araddr[1], 32'h0001_0020);
        s_arready = 2'b11;
        #1;
        check("t4_m_arready", 32'(m_arready), 32'h5);
        tick();
        m_arvalid  = '0;
        s_arready  = '0;
        s_rvalid   = 2'b11;
        s_rdata[0] = 32'hAAAA_0000;
        s_rdata[1] = 32'hBBBB_2222;
        s_rresp[0] = RESP_OKAY;
        s_rresp[1] = RESP_SLVERR;
        #1;
        check("t4_m_rvalid", 32'(m_rvalid), 32'h5);
        check("t4_m_rdata0", m_rdata[0], 32'hAAAA_0000);
        check("t4_m_rdata2", m_rdata[2], 32'hBBBB_2222);
        check("t4_m_rresp2", 32'(m_rresp[2]), 32'h2);
        tick();
        s_rvalid   = '0;
        s_rresp[1] = RESP_OKAY;
        #1;
        check("t4_m_rvalid_done", 32'(m_rvalid), 32'h0);

        // 5) M3 reads S0 but holds rready low for 5 cycles
        m_araddr[3] = 32'h0000_0008;
        m_rready    = 4'b0111;
        m_arvalid   = 4'b1000;
        tick();
        check("t5_s_araddr0", s_araddr[0], 32'h0000_0008);
        s_arready[0] = 1'b1;
        tick();
        m_arvalid   = '0;
        s_arready   = '0;
        s_rvalid[0] = 1'b1;
        s_rdata[0]  = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t5_s_rready_c%0d", i), 32'(s_rready), 32'h0);
            check($sformatf("t5_m_rvalid_c%0d", i), 32'(m_rvalid), 32'h8);
            check($sformatf("t5_m_rdata3_c%0d", i), m_rdata[3], 32'h1234_5678);
            tick();
        end
        m_rready = 4'b1111;
        #1;
        check("t5_s_rready", 32'(s_rready), 32'h1);
        tick();
        s_rvalid = '0;
        #1;
        check("t5_m_rvalid_done", 32'(m_rvalid), 32'h0);
        check("t5_s_rready_done", 32'(s_rready), 32'h0);

        // 6a) Reset while S0 is in DATA for M1
        m_araddr[1] = 32'h0000_0010;
        m_arvalid   = 4'b0010;
        tick();
        s_arready[0] = 1'b1;
        tick();
        m_arvalid = '0;
        s_arready = '0;
        tick();
        check("t6_waiting_rvalid", 32'(m_rvalid), 32'h0);
        check("t6_waiting_s_rready", 32'(s_rready), 32'h1);
        aresetn = 1'b0;
        #1;
        check("t6_rst_s_arvalid", 32'(s_arvalid), 32'h0);
        check("t6_rst_s_rready",  32'(s_rready),  32'h0);
        check("t6_rst_m_rvalid",  32'(m_rvalid),  32'h0);
        check("t6_rst_m_arready", 32'(m_arready), 32'h0);
        s_rvalid[0] = 1'b1;
        s_rdata[0]  = 32'hDEAD_BEEF;
        tick();
        aresetn = 1'b1;
        tick();
        tick();
        check("t6_late_m_rvalid", 32'(m_rvalid), 32'h0);
        check("t6_late_s_rready", 32'(s_rready), 32'h0);
        check("t6_late_s_arvalid", 32'(s_arvalid), 32'h0);
        s_rvalid = '0;
        tick();

`ifdef AXIL_RD_TIMEOUT_EN
        // 6b) S0 silent for 256 cycles in DATA -> SLVERR, then drain the late beat
        m_araddr[0] = 32'h0000_0000;
        m_rready    = 4'b1110;
        m_arvalid   = 4'b0001;
        tick();
        s_arready[0] = 1'b1;
        tick();
        m_arvalid = '0;
        s_arready = '0;
        repeat (255) tick();
        check("t6_to_before_limit", 32'(m_rvalid), 32'h0);
        tick();
        check("t6_to_rvalid", 32'(m_rvalid), 32'h1);
        check("t6_to_rresp0", 32'(m_rresp[0]), 32'h2);
        check("t6_to_rdata0", m_rdata[0], 32'h0);
        check("t6_to_drain_rready", 32'(s_rready), 32'h1);
        m_rready = 4'b1111;
        tick();
        check("t6_to_rvalid_done", 32'(m_rvalid), 32'h0);
        check("t6_to_still_draining", 32'(s_rready), 32'h1);
        s_rvalid[0] = 1'b1;
        s_rdata[0]  = 32'h55AA_55AA;
        #1;
        check("t6_to_late_discarded", 32'(m_rvalid), 32'h0);
        tick();
        s_rvalid = '0;
        #1;
        check("t6_to_idle_s_rready", 32'(s_rready), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
